// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: baud divisors at a 12 MHz system clock and datapath widths.
// The macros are visible to every file compiled after this one.
`ifndef UART_BAUD_DEFS
`define UART_BAUD_DEFS
`define B115200 104
`define B57600  208
`define B38400  312
`define B19200  625
`define B9600   1250
`endif

package uart_rx_pkg;
    localparam int CNT_W  = 16;
    localparam int DATA_W = 8;
    localparam int IDX_W  = 3;
endpackage

// File: rtl/uart_rx_rx_sync.sv
// Multi-flop synchronizer for an asynchronous input pin; flops reset to the idle level 1.
module rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling driven by a reloadable baud counter,
// one-cycle rcv strobe for good frames and ferr strobe on a bad stop bit.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUDRATE = `B115200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [DATA_W-1:0] data,
    output logic              rcv,
    output logic              busy,
    output logic              ferr
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUDRATE - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUDRATE / 2 - 1);

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [DATA_W-1:0]   shift_reg, shift_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [DATA_W-1:0]   data_reg, data_next;
    logic                rcv_reg, rcv_next;
    logic                ferr_reg, ferr_next;
    logic                rx_s;
    logic                tick;

    rx_sync #(.STAGES(2)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign tick = (cnt_reg == '0);

    always_comb begin
        state_next = state_reg;
        cnt_next   = tick ? cnt_reg : cnt_reg - CNT_W'(1);
        shift_next = shift_reg;
        idx_next   = idx_reg;
        data_next  = data_reg;
        rcv_next   = 1'b0;
        ferr_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    cnt_next   = HALF_LOAD;
                end
            end
            START: begin
                // A line that is high again at mid start bit was only a glitch
                if (tick) begin
                    if (!rx_s) begin
                        state_next = DATA;
                        cnt_next   = FULL_LOAD;
                        idx_next   = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_next = {rx_s, shift_reg[DATA_W-1:1]};
                    cnt_next   = FULL_LOAD;
                    idx_next   = idx_reg + IDX_W'(1);
                    if (idx_reg == IDX_W'(DATA_W - 1)) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        data_next  = shift_reg;
                        rcv_next   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // Hold off until the line returns high so a break yields one error only
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            shift_reg <= '0;
            idx_reg   <= '0;
            data_reg  <= '0;
            rcv_reg   <= 1'b0;
            ferr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            shift_reg <= shift_next;
            idx_reg   <= idx_next;
            data_reg  <= data_next;
            rcv_reg   <= rcv_next;
            ferr_reg  <= ferr_next;
        end
    end

    assign data = data_reg;
    assign rcv  = rcv_reg;
    assign ferr = ferr_reg;
    assign busy = (state_reg != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: good frames, back-to-back, glitch, framing error,
// mid-frame reset, transmitter loopback and +/-3 % baud offset.
`ifndef B115200
`define B115200 104
`endif

module tb_uart_rx;
    localparam int B = `B115200;
    localparam int LATENCY = 3 + B / 2 + 9 * B;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       rcv;
    logic       busy;
    logic       ferr;

    uart_rx #(.BAUDRATE(B)) dut (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .data (data),
        .rcv  (rcv),
        .busy (busy),
        .ferr (ferr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         rcv_cnt = 0;
    int         ferr_cnt = 0;
    int         both_cnt = 0;
    int         busy_cnt = 0;
    int         rcv_cyc = 0;
    logic [7:0] rcv_q[$];

    always @(negedge clk) begin
        if (rcv) begin
            rcv_cnt = rcv_cnt + 1;
            rcv_cyc = cyc;
            rcv_q.push_back(data);
        end
        if (ferr) ferr_cnt = ferr_cnt + 1;
        if (rcv && ferr) both_cnt = both_cnt + 1;
        if (busy) busy_cnt = busy_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    function automatic logic [31:0] pop_byte();
        if (rcv_q.size() > 0) return {24'd0, rcv_q.pop_front()};
        return 32'hDEAD;
    endfunction

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge; every bit lasts 'per' cycles; line left at the stop value.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int per);
        rx = 1'b0;
        hold(per);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            hold(per);
        end
        rx = stop;
        hold(per);
    endtask

    // Simple transmitter model: shifts a 10-bit {stop, data, start} frame out LSB first.
    task automatic uart_tx_model(input logic [7:0] b, input int per);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[0];
            frame = {1'b1, frame[9:1]};
            hold(per);
        end
    endtask

    int t0, r0, f0, b0;

    initial begin
        hold(4);
        rst = 1'b0;
        hold(1);
        chk("reset_data", {24'd0, data}, 32'h00);
        chk("reset_rcv", {31'd0, rcv}, 32'd0);
        chk("reset_ferr", {31'd0, ferr}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);

        hold(20 * B);
        chk("idle_rcv_cnt", rcv_cnt, 0);
        chk("idle_ferr_cnt", ferr_cnt, 0);
        chk("idle_busy_cnt", busy_cnt, 0);
        chk("idle_data", {24'd0, data}, 32'h00);

        // Single character with latency check
        t0 = cyc;
        send_frame(8'h41, 1'b1, B);
        hold(B);
        chk("a_rcv_cnt", rcv_cnt, 1);
        chk("a_byte", pop_byte(), 32'h41);
        chk("a_latency", rcv_cyc - t0, LATENCY);
        chk("a_data_hold", {24'd0, data}, 32'h41);

        // Back-to-back characters
        r0 = rcv_cnt;
        send_frame(8'h55, 1'b1, B);
        send_frame(8'hAA, 1'b1, B);
        send_frame(8'h00, 1'b1, B);
        hold(B);
        chk("b2b_rcv_cnt", rcv_cnt - r0, 3);
        chk("b2b_byte0", pop_byte(), 32'h55);
        chk("b2b_byte1", pop_byte(), 32'hAA);
        chk("b2b_byte2", pop_byte(), 32'h00);
        chk("b2b_ferr_cnt", ferr_cnt, 0);

        // Short low glitch
        r0 = rcv_cnt; f0 = ferr_cnt; b0 = busy_cnt;
        rx = 1'b0;
        hold(B / 4);
        rx = 1'b1;
        hold(2 * B);
        chk("glitch_busy_seen", {31'd0, (busy_cnt - b0) > 0}, 32'd1);
        chk("glitch_busy_short", {31'd0, (busy_cnt - b0) < B}, 32'd1);
        chk("glitch_rcv_cnt", rcv_cnt - r0, 0);
        chk("glitch_ferr_cnt", ferr_cnt - f0, 0);
        chk("glitch_busy_end", {31'd0, busy}, 32'd0);

        // Framing error followed by a long break, then a good character
        r0 = rcv_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, B);
        hold(30 * B);
        chk("ferr_cnt", ferr_cnt - f0, 1);
        chk("ferr_rcv_cnt", rcv_cnt - r0, 0);
        chk("ferr_data_kept", {24'd0, data}, 32'h00);
        chk("ferr_busy_wait", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        hold(B);
        send_frame(8'h21, 1'b1, B);
        hold(B);
        chk("after_ferr_rcv_cnt", rcv_cnt - r0, 1);
        chk("after_ferr_byte", pop_byte(), 32'h21);
        chk("after_ferr_ferr_cnt", ferr_cnt - f0, 1);

        // Reset in the middle of the data bits of 0x7E
        r0 = rcv_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        hold(B);
        rx = 1'b0; hold(B);
        rx = 1'b1; hold(B);
        rx = 1'b1; hold(B);
        rx = 1'b1; hold(B / 2);
        rst = 1'b1;
        hold(1);
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rx = 1'b1;
        hold(2 * B);
        chk("rst_rcv_cnt", rcv_cnt - r0, 0);
        chk("rst_ferr_cnt", ferr_cnt - f0, 0);
        send_frame(8'h31, 1'b1, B);
        hold(B);
        chk("post_rst_rcv_cnt", rcv_cnt - r0, 1);
        chk("post_rst_byte", pop_byte(), 32'h31);

        // Loopback from the transmitter model
        r0 = rcv_cnt;
        uart_tx_model(8'h41, B);
        hold(B);
        chk("loop_rcv_cnt", rcv_cnt - r0, 1);
        chk("loop_byte", pop_byte(), 32'h41);

        // Transmitter about 3 % slow and 3 % fast
        r0 = rcv_cnt;
        uart_tx_model(8'h96, B + B * 3 / 100);
        hold(B);
        uart_tx_model(8'h69, B - B * 3 / 100);
        hold(B);
        chk("skew_rcv_cnt", rcv_cnt - r0, 2);
        chk("skew_slow_byte", pop_byte(), 32'h96);
        chk("skew_fast_byte", pop_byte(), 32'h69);

        chk("never_both", both_cnt, 0);
        chk("total_ferr", ferr_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART peripheral family: recovers 8N1 characters from the `rx` line and presents each byte with a one-cycle valid strobe. It is the receive-side counterpart of the existing UART transmitter, using the same baud-divisor constants, so tx-to-rx loopback benches work without translation. It sits between the board's RX pin and any character consumer (echo, command parser, FIFO).

## Interface
- `BAUDRATE`, default `` `B115200 `` (104 at 12 MHz): clock cycles per bit; legal range 4..65535.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input; idle high.
- `data`  out  8  last correctly framed byte; holds until the next good byte.
- `rcv`  out  1  one-cycle strobe; `data` is valid in the same cycle.
- `busy`  out  1  high while a frame is being received (state ≠ IDLE).
- `ferr`  out  1  one-cycle strobe on stop-bit error.

## Operation
- `rx` passes through a 2-flop synchronizer (`rx_s`). Synchronizer flops reset to 1.
- 16-bit baud counter: loaded on entry to each timed state; a sample tick fires when it reaches 0.
- FSM states:
  - IDLE: when `rx_s`=0, load counter with `BAUDRATE/2`-1 and go to START.
  - START: on tick, if `rx_s`=0, load `BAUDRATE`-1, clear bit index, and go to DATA. If `rx_s`=1, treat as a glitch and return to IDLE with no strobe.
  - DATA: on each tick, shift `rx_s` into a shift register LSB-first, reload `BAUDRATE`-1, and increment the 3-bit index. After bit 7, go to STOP.
  - STOP: on tick, if `rx_s`=1, copy the shift register to `data`, pulse `rcv`, and go to IDLE. If `rx_s`=0, pulse `ferr`, leave `data` unchanged, and go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s`=1, then go to IDLE. This prevents a break or stuck-low line from producing repeated frames.
- Reset values: `data`=0x00, `rcv`=0, `ferr`=0, `busy`=0; state=IDLE; counter=0.
- `rst` asserted mid-frame aborts at the next edge with no strobe. The partial byte is discarded.
- A new start bit arriving immediately after a good stop sample (back-to-back characters) is accepted. IDLE detects it on the first cycle back.
- `rcv` and `ferr` are never high together.

## Timing
- Let edge E be the first clock edge at which the first synchronizer flop captures 0 for the start bit.
  - `rx_s`=0 is visible at E+2; the FSM enters START at E+2.
  - Start sample at E+2+`BAUDRATE/2`.
  - Data bit k is sampled at start sample + (k+1)·`BAUDRATE`.
  - Stop bit is sampled at start sample + 9·`BAUDRATE`.
  - `rcv`/`ferr` are high in the cycle after the stop sample. `busy` falls on the same edge.
- Total latency from E to `rcv`: 3 + `BAUDRATE/2` + 9·`BAUDRATE` cycles.
- Tolerated transmitter baud mismatch: ±4 % (mid-bit sampling).
- `rcv` and `ferr` are registered outputs, one cycle wide.
- `data` changes only on the edge that raises `rcv`.

## Structure
- Baud-divisor macros (`B115200`, `B57600`, ...) stay in the shared baud header. `uart_rx` includes it.
- FSM state encodings are localparams inside the module.
- One sub-module, `rx_sync`: 2-flop synchronizer with reset value 1, reusable by other input pins.
- Counter, shift register and FSM stay in `uart_rx`. The RTL is roughly 150 lines.

## Test plan
- Reset, then hold `rx`=1 for 20·`BAUDRATE` cycles: `rcv`, `ferr`, `busy` stay 0; `data`=0x00.
- Drive 0x41 ('A') at exactly `BAUDRATE`: `rcv` pulses once with `data`=0x41 at the latency above (±1 cycle).
- Drive 0x55, then 0xAA, then 0x00 back-to-back with no idle gap: three `rcv` pulses, with `data`=0x55, 0xAA, 0x00 in order.
- Drive a low glitch of `BAUDRATE/4` cycles: `busy` pulses briefly; no `rcv` or `ferr`; FSM returns to IDLE.
- Frame 0x3C with the stop bit driven 0, then the line held low for 3 character times, then 0x21 sent:
  - one `ferr` pulse;
  - `data` keeps its previous value;
  - no further strobes while the line is low;
  - `rcv` with `data`=0x21.
- Assert `rst` for 1 cycle mid-DATA of 0x7E: no strobe; `busy`=0 the next cycle; a following 0x31 is received correctly.
- Loopback from the UART transmitter at `` `B115200 ``, character 'A': `data`=0x41 on `rcv`.
